// File: rtl/cmp_cal_sequencer.sv
// Comparator offset-trim calibration sequencer for the flash ADC array.
// One sample counter and one trim-search engine are time-shared across the
// comparators. Each comparator's left/right trim is walked toward a 50 % high
// duty on its shorted-input output, then stored in a bank that drives the array.
module cmp_cal_sequencer #(
  parameter int N_CMP       = 15,
  parameter int TRIM_W      = 5,
  parameter int CAL_SAMPLES = 250,
  parameter int TOL         = 10,
  parameter int SETTLE      = 8,
  localparam int SEL_W      = (N_CMP > 1) ? $clog2(N_CMP) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [N_CMP-1:0]          i_cmp_out,
  output logic                      o_cal_mode,
  output logic [SEL_W-1:0]          o_sel,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [N_CMP*TRIM_W-1:0]   o_b_left,
  output logic [N_CMP*TRIM_W-1:0]   o_b_right,
  output logic [N_CMP-1:0]          o_sat
);

  localparam int CNT_W = $clog2(CAL_SAMPLES + 1);
  localparam int D_W   = $clog2(CAL_SAMPLES) + 2;
  localparam int TMR_W = $clog2(((SETTLE > CAL_SAMPLES) ? SETTLE : CAL_SAMPLES) + 1);
  localparam int HALF  = CAL_SAMPLES / 2;
  localparam logic [TRIM_W-1:0] TRIM_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_NEXT
  } state_t;

  // Which trim the search last incremented; used for overshoot step-back.
  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t             r_state;
  dir_t               r_dir;
  logic [SEL_W-1:0]   r_sel;
  logic [CNT_W-1:0]   r_count;
  logic [TMR_W-1:0]   r_tmr;
  logic [D_W-1:0]     r_last_abs;
  logic [TRIM_W-1:0]  r_left  [N_CMP];
  logic [TRIM_W-1:0]  r_right [N_CMP];
  logic [N_CMP-1:0]   r_sat;
  logic               r_busy;
  logic               r_cal_mode;
  logic               r_done;

  // Window evaluation: signed distance of the ones-count from half the window.
  logic                   w_bit;
  logic signed [D_W-1:0]  w_d;
  logic                   w_neg;
  logic                   w_pos;
  logic [D_W-1:0]         w_abs;
  logic                   w_within_tol;
  logic                   w_worse;
  logic                   w_opposes;
  logic [TRIM_W-1:0]      w_cur_l;
  logic [TRIM_W-1:0]      w_cur_r;

  assign w_bit        = i_cmp_out[r_sel];
  assign w_d          = $signed(D_W'(r_count)) - $signed(D_W'(HALF));
  assign w_neg        = w_d[D_W-1];
  assign w_pos        = !w_neg && (w_d != '0);
  assign w_abs        = w_neg ? -w_d : w_d;
  assign w_within_tol = (w_abs <= D_W'(TOL));
  assign w_worse      = (w_abs > r_last_abs);
  assign w_opposes    = ((r_dir == DIR_LEFT) && w_neg) || ((r_dir == DIR_RIGHT) && w_pos);
  assign w_cur_l      = r_left[r_sel];
  assign w_cur_r      = r_right[r_sel];

  // Sequencer FSM: owns the selected entry of the trim bank and all status outputs.
  // NOTE: every register here is updated with <= so all reads see pre-edge values.
  // NOTE: the trim bank is flops driving the array directly, so it is reset like
  // any other state; a reset mid-run must leave every comparator untrimmed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_dir      <= DIR_NONE;
      r_sel      <= '0;
      r_count    <= '0;
      r_tmr      <= '0;
      r_last_abs <= '0;
      r_sat      <= '0;
      r_busy     <= 1'b0;
      r_cal_mode <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < N_CMP; i++) begin
        r_left[i]  <= '0;
        r_right[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (i_abort && (r_state != S_IDLE)) begin
        r_state        <= S_IDLE;
        r_dir          <= DIR_NONE;
        r_left[r_sel]  <= '0;
        r_right[r_sel] <= '0;
        r_sat[r_sel]   <= 1'b0;
        r_sel          <= '0;
        r_count        <= '0;
        r_tmr          <= '0;
        r_busy         <= 1'b0;
        r_cal_mode     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              r_state    <= S_LOAD;
              r_busy     <= 1'b1;
              r_cal_mode <= 1'b1;
            end
          end
          S_LOAD: begin
            r_left[r_sel]  <= '0;
            r_right[r_sel] <= '0;
            r_sat[r_sel]   <= 1'b0;
            r_last_abs     <= D_W'(CAL_SAMPLES);
            r_dir          <= DIR_NONE;
            r_count        <= '0;
            r_tmr          <= '0;
            r_state        <= S_SETTLE;
          end
          S_SETTLE: begin
            if (r_tmr == TMR_W'(SETTLE - 1)) begin
              r_tmr   <= '0;
              r_state <= S_SAMPLE;
            end else begin
              r_tmr <= r_tmr + TMR_W'(1);
            end
          end
          S_SAMPLE: begin
            r_count <= r_count + CNT_W'(w_bit);
            if (r_tmr == TMR_W'(CAL_SAMPLES - 1)) begin
              r_tmr   <= '0;
              r_state <= S_EVAL;
            end else begin
              r_tmr <= r_tmr + TMR_W'(1);
            end
          end
          S_EVAL: begin
            r_count    <= '0;
            r_last_abs <= w_abs;
            r_state    <= S_SETTLE;
            if (w_within_tol) begin
              r_state <= S_NEXT;
            end else if ((r_dir != DIR_NONE) && (w_opposes || w_worse)) begin
              // Past the balance point: undo the last step only if it made things worse.
              if (w_worse && (r_dir == DIR_LEFT))  r_left[r_sel]  <= w_cur_l - TRIM_W'(1);
              if (w_worse && (r_dir == DIR_RIGHT)) r_right[r_sel] <= w_cur_r - TRIM_W'(1);
              r_state <= S_NEXT;
            end else if (w_pos) begin
              if (w_cur_l == TRIM_MAX) begin
                r_sat[r_sel] <= 1'b1;
                r_state      <= S_NEXT;
              end else begin
                r_left[r_sel] <= w_cur_l + TRIM_W'(1);
                r_dir         <= DIR_LEFT;
              end
            end else begin
              if (w_cur_r == TRIM_MAX) begin
                r_sat[r_sel] <= 1'b1;
                r_state      <= S_NEXT;
              end else begin
                r_right[r_sel] <= w_cur_r + TRIM_W'(1);
                r_dir          <= DIR_RIGHT;
              end
            end
          end
          S_NEXT: begin
            if (r_sel == SEL_W'(N_CMP - 1)) begin
              r_done     <= 1'b1;
              r_sel      <= '0;
              r_busy     <= 1'b0;
              r_cal_mode <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_sel   <= r_sel + SEL_W'(1);
              r_state <= S_LOAD;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Flatten the trim bank onto the packed output buses.
  // NOTE: outputs get a default before the loop so no latch can be inferred.
  always_comb begin
    o_b_left  = '0;
    o_b_right = '0;
    for (int i = 0; i < N_CMP; i++) begin
      o_b_left[i*TRIM_W +: TRIM_W]  = r_left[i];
      o_b_right[i*TRIM_W +: TRIM_W] = r_right[i];
    end
  end

  assign o_sel      = r_sel;
  assign o_sat      = r_sat;
  assign o_busy     = r_busy;
  assign o_cal_mode = r_cal_mode;
  assign o_done     = r_done;

endmodule

// File: tb/tb_cmp_cal_sequencer.sv
// Self-checking bench for cmp_cal_sequencer. A comparator plant turns the
// current trims into a duty cycle; a search model derived from the trim rules
// predicts final trims, saturation flags and total run latency.
module tb_cmp_cal_sequencer;

  localparam int N_CMP  = 3;
  localparam int TRIM_W = 5;
  localparam int CAL    = 16;
  localparam int TOL    = 1;
  localparam int SETTLE = 2;
  localparam int SEL_W  = 2;
  localparam int ITER   = SETTLE + CAL + 1;
  localparam int MAXT   = (1 << TRIM_W) - 1;
  localparam int BUDGET = N_CMP * (2 + 32 * ITER) + 20;

  logic                     clk;
  logic                     rst_n;
  logic                     i_start;
  logic                     i_abort;
  logic [N_CMP-1:0]         i_cmp_out;
  logic                     o_cal_mode;
  logic [SEL_W-1:0]         o_sel;
  logic                     o_busy;
  logic                     o_done;
  logic [N_CMP*TRIM_W-1:0]  o_b_left;
  logic [N_CMP*TRIM_W-1:0]  o_b_right;
  logic [N_CMP-1:0]         o_sat;

  cmp_cal_sequencer #(
    .N_CMP(N_CMP), .TRIM_W(TRIM_W), .CAL_SAMPLES(CAL), .TOL(TOL), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_cmp_out(i_cmp_out), .o_cal_mode(o_cal_mode), .o_sel(o_sel),
    .o_busy(o_busy), .o_done(o_done), .o_b_left(o_b_left),
    .o_b_right(o_b_right), .o_sat(o_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- comparator plant ----------------
  int          off   [N_CMP];
  int          phase [N_CMP];
  bit          overshoot;
  int unsigned tcyc;

  // Ones per window as a function of trims.
  function automatic int k_of(input int i, input int l, input int r);
    int k;
    if (overshoot && i == 0) begin
      k = (l == 0) ? 13 : (l == 1) ? 11 : 2;
    end else begin
      k = CAL / 2 + 2 * (off[i] - l + r);
      if (k < 0) k = 0;
      if (k > CAL) k = CAL;
    end
    return k;
  endfunction

  // Period-CAL permuted pattern: any CAL consecutive cycles hold exactly k ones.
  always @(negedge clk) begin
    tcyc++;
    for (int i = 0; i < N_CMP; i++) begin
      int l, r, pos;
      l   = int'(o_b_left[i*TRIM_W +: TRIM_W]);
      r   = int'(o_b_right[i*TRIM_W +: TRIM_W]);
      pos = int'(((tcyc + phase[i]) * 5) % CAL);
      i_cmp_out[i] = (pos < k_of(i, l, r));
    end
  end

  always @(negedge clk) if (o_done === 1'b1) n_done++;

  // ---------------- reference search model ----------------
  int exp_l [N_CMP];
  int exp_r [N_CMP];
  int exp_s [N_CMP];
  int exp_cyc;

  task automatic ref_search(input int i, output int l, output int r, output int s, output int it);
    int  last, dir, d, a;
    bit  fin;
    l = 0; r = 0; s = 0; it = 0; last = CAL; dir = 0; fin = 0;
    while (!fin) begin
      it++;
      d = k_of(i, l, r) - CAL / 2;
      a = (d < 0) ? -d : d;
      if (a <= TOL) begin
        fin = 1;
      end else if (dir != 0 && (((dir > 0) != (d > 0)) || a > last)) begin
        if (a > last) begin
          if (dir > 0) l--; else r--;
        end
        fin = 1;
      end else if (d > 0) begin
        if (l == MAXT) begin s = 1; fin = 1; end
        else begin l++; dir = 1; end
      end else begin
        if (r == MAXT) begin s = 1; fin = 1; end
        else begin r++; dir = -1; end
      end
      last = a;
    end
  endtask

  task automatic ref_run();
    int it;
    exp_cyc = 0;
    for (int i = 0; i < N_CMP; i++) begin
      ref_search(i, exp_l[i], exp_r[i], exp_s[i], it);
      exp_cyc += 2 + it * ITER;
    end
  endtask

  // Start a full calibration; wait for busy to rise.
  task automatic kick(input string tag);
    @(negedge clk) i_start = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy rise"}, 64'(o_busy), 64'd1);
    check({tag, " cal_mode rise"}, 64'(o_cal_mode), 64'd1);
    i_start = 1'b0;
  endtask

  // Full run checked against the model; optional start pulse mid-run.
  task automatic do_run(input string tag, input int pulse_at);
    int waited, dones0;
    bit got;
    ref_run();
    dones0 = n_done;
    kick(tag);
    waited = 0; got = 0;
    while (waited < BUDGET && !got) begin
      @(posedge clk); #1;
      waited++;
      if (waited == pulse_at) i_start = 1'b1;
      else if (waited == pulse_at + 1) i_start = 1'b0;
      if (o_done === 1'b1) got = 1;
    end
    check({tag, " done latency"}, 64'(waited), 64'(exp_cyc));
    check({tag, " busy at done"}, 64'(o_busy), 64'd0);
    check({tag, " sel at done"}, 64'(o_sel), 64'd0);
    for (int i = 0; i < N_CMP; i++) begin
      check($sformatf("%s left[%0d]", tag, i), 64'(o_b_left[i*TRIM_W +: TRIM_W]), 64'(exp_l[i]));
      check($sformatf("%s right[%0d]", tag, i), 64'(o_b_right[i*TRIM_W +: TRIM_W]), 64'(exp_r[i]));
      check($sformatf("%s sat[%0d]", tag, i), 64'(o_sat[i]), 64'(exp_s[i]));
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, " idle after done"}, 64'(o_busy), 64'd0);
    check({tag, " single done"}, 64'(n_done - dones0), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_cmp_out = '0;
    overshoot = 0; tcyc = 0;
    for (int i = 0; i < N_CMP; i++) begin off[i] = 0; phase[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(o_busy), 64'd0);
    check("reset cal_mode", 64'(o_cal_mode), 64'd0);
    check("reset done", 64'(o_done), 64'd0);
    check("reset sel", 64'(o_sel), 64'd0);
    check("reset left", 64'(o_b_left), 64'd0);
    check("reset right", 64'(o_b_right), 64'd0);
    check("reset sat", 64'(o_sat), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Positive offset, with a start pulse mid-run that must be ignored.
    off[0] = 3; off[1] = 0; off[2] = -2;
    do_run("posoff", 50);

    // Overshoot on comparator 0: step back to left=1.
    overshoot = 1; off[0] = 0; off[1] = 1; off[2] = 0;
    do_run("overshoot", 0);
    overshoot = 0;

    // Saturation on comparator 0.
    off[0] = 40; off[1] = 0; off[2] = -1;
    do_run("saturate", 0);

    // Abort during comparator 1's second SAMPLE window.
    off[0] = 3; off[1] = 2; off[2] = -2;
    kick("abort");
    repeat (105) @(posedge clk);
    #1;
    check("abort pre left1", 64'(o_b_left[1*TRIM_W +: TRIM_W]), 64'd1);
    check("abort pre sel", 64'(o_sel), 64'd1);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    check("abort busy", 64'(o_busy), 64'd0);
    check("abort cal_mode", 64'(o_cal_mode), 64'd0);
    check("abort done", 64'(o_done), 64'd0);
    check("abort sel", 64'(o_sel), 64'd0);
    check("abort keep left0", 64'(o_b_left[0 +: TRIM_W]), 64'd3);
    check("abort clr left1", 64'(o_b_left[1*TRIM_W +: TRIM_W]), 64'd0);
    check("abort clr right1", 64'(o_b_right[1*TRIM_W +: TRIM_W]), 64'd0);

    // Abort and start together in IDLE: stay idle.
    @(negedge clk) begin i_abort = 1'b1; i_start = 1'b1; end
    repeat (2) @(posedge clk);
    #1;
    check("abort+start idle", 64'(o_busy), 64'd0);
    i_abort = 1'b0; i_start = 1'b0;

    // Reset mid-SAMPLE of comparator 1 after comparator 0 locked.
    off[0] = 3; off[1] = 0; off[2] = -2;
    kick("rstmid");
    repeat (86) @(posedge clk);
    #1;
    check("rstmid pre left0", 64'(o_b_left[0 +: TRIM_W]), 64'd3);
    rst_n = 1'b0;
    #1;
    check("rstmid busy", 64'(o_busy), 64'd0);
    check("rstmid cal_mode", 64'(o_cal_mode), 64'd0);
    check("rstmid sel", 64'(o_sel), 64'd0);
    check("rstmid left", 64'(o_b_left), 64'd0);
    check("rstmid right", 64'(o_b_right), 64'd0);
    check("rstmid sat", 64'(o_sat), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Randomized offsets and sample patterns.
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < N_CMP; i++) begin
        off[i]   = int'($urandom_range(0, 14)) - 7;
        phase[i] = int'($urandom_range(0, CAL - 1));
      end
      do_run($sformatf("rand%0d", n), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
